// File: rtl/idct_row_seq.sv
// Sequential 8-point 1-D inverse DCT: one coefficient row in, eight clipped 8-bit pixels out.
// Optional build macro IDCT_ZERO_SKIP_EN stops accumulation after the last nonzero coefficient.
module idct_row_seq #(
  parameter int FRAC  = 12,
  parameter int ACC_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out
);

  // state | meaning
  // IDLE  | waiting for a coefficient row, in_ready=1
  // ACC   | one MAC step per cycle over k, then one cycle to round/clip
  // OUT   | pixel row held until out_ready
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);

  state_t                  state;
  logic [2:0]              k;
  logic                    fin;
  logic signed [8:0]       y    [8];
  logic signed [ACC_W-1:0] acc  [8];
  logic signed [ACC_W-1:0] prod [8];
  logic signed [ACC_W-1:0] cext [8];
  logic signed [ACC_W-1:0] rnd  [8];
  logic signed [ACC_W-1:0] shf  [8];
  logic signed [ACC_W-1:0] ysel;
  logic signed [13:0]      coef [8];
  logic [7:0]              pix  [8];
  logic [2:0]              last;

  // Cosine weight for output n, coefficient k: reduce (2n+1)k*pi/16 into the first quadrant.
  // Angle index 0 only occurs for k=0, so the 1/sqrt(2) entry doubles as the C(0) term.
  function automatic logic signed [13:0] kcoef(input int n, input int kk);
    int                 m;
    logic               neg;
    logic signed [13:0] mag;
    m   = ((2 * n + 1) * kk) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      0:       mag = 14'sd5793;
      1:       mag = 14'sd8035;
      2:       mag = 14'sd7568;
      3:       mag = 14'sd6811;
      4:       mag = 14'sd5793;
      5:       mag = 14'sd4551;
      6:       mag = 14'sd3135;
      7:       mag = 14'sd1598;
      default: mag = 14'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

  always_comb begin
    ysel = {{(ACC_W-9){y[k][8]}}, y[k]};
    for (int n = 0; n < 8; n++) begin
      coef[n] = kcoef(n, int'(k));
      cext[n] = {{(ACC_W-14){coef[n][13]}}, coef[n]};
      prod[n] = ysel * cext[n];
      rnd[n]  = acc[n] + HALF;
      shf[n]  = rnd[n] >>> FRAC;
      if (shf[n][ACC_W-1])
        pix[n] = 8'd0;
      else if (shf[n] > ACC_W'(255))
        pix[n] = 8'd255;
      else
        pix[n] = shf[n][7:0];
    end
  end

`ifdef IDCT_ZERO_SKIP_EN
  logic [2:0] lastnz_in;
  logic       zero_in;

  always_comb begin
    lastnz_in = 3'd0;
    zero_in   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in[71-9*i -: 9] != 9'd0) begin
        lastnz_in = 3'(i);
        zero_in   = 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 3'd0;
      fin       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= 64'd0;
`ifdef IDCT_ZERO_SKIP_EN
      last      <= 3'd0;
`endif
      for (int n = 0; n < 8; n++) begin
        acc[n] <= '0;
        y[n]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int n = 0; n < 8; n++) begin
              y[n]   <= in[71-9*n -: 9];
              acc[n] <= '0;
            end
            k        <= 3'd0;
            fin      <= 1'b0;
            in_ready <= 1'b0;
`ifdef IDCT_ZERO_SKIP_EN
            last     <= lastnz_in;
            if (zero_in) begin
              out       <= 64'd0;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              state <= ACC;
            end
`else
            state    <= ACC;
`endif
          end
        end
        ACC: begin
          if (fin) begin
            for (int n = 0; n < 8; n++) out[63-8*n -: 8] <= pix[n];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            for (int n = 0; n < 8; n++) acc[n] <= acc[n] + prod[n];
            k <= k + 3'd1;
            if (k == last) fin <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef IDCT_ZERO_SKIP_EN
  assign last = 3'd7;
`endif

endmodule

// File: tb/tb_idct_row_seq.sv
// Randomized bench for idct_row_seq against a floating-point-derived IDCT reference.
module tb_idct_row_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  localparam real PI = 3.14159265358979323846;

  idct_row_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack(input int y[8]);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[71-9*i -: 9] = 9'(y[i]);
    return p;
  endfunction

  // x[n] = sum_k Y_k * round(8192*C(k)*cos((2n+1)k*pi/16)), then round by 2^12 and clip.
  function automatic logic [63:0] model(input int y[8]);
    logic [63:0] p;
    int acc, kk, v;
    real c, r;
    p = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        c  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        r  = 8192.0 * c * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        kk = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        acc += y[k] * kk;
      end
      v = (acc + 2048) >>> 12;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      p[63-8*n -: 8] = 8'(v);
    end
    return p;
  endfunction

  function automatic int exp_lat(input int y[8]);
`ifdef IDCT_ZERO_SKIP_EN
    int lz;
    lz = -1;
    for (int i = 0; i < 8; i++) if (y[i] != 0) lz = i;
    return (lz < 0) ? 1 : lz + 2;
`else
    return 9;
`endif
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom, $urandom, $urandom});
  endfunction

  task automatic run_row(input int y[8], input int stall, output logic [63:0] pix);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    din      = pack(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = rnd72();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'(exp_lat(y)));
    check("out_valid", 64'(out_valid), 64'd1);
    check("in_ready_busy", 64'(in_ready), 64'd0);
    pix = dout;
    for (int s = 0; s < stall; s++) begin
      din      = rnd72();
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_hold", dout, pix);
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("done_valid", 64'(out_valid), 64'd0);
    check("done_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int y[8];
    logic [63:0] pix;
    int lz;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", dout, 64'd0);
    rst = 1'b0;

    y = '{90, 0, 0, 0, 0, 0, 0, 0};
    run_row(y, 0, pix);
    check("y0_90", pix, {8{8'd127}});

    y = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_row(y, 0, pix);
    check("all_zero", pix, 64'd0);

    y = '{0, 100, 0, 0, 0, 0, 0, 0};
    run_row(y, 0, pix);
    check("y1_x0", 64'(pix[63:56]), 64'd196);
    check("y1_x1", 64'(pix[55:48]), 64'd166);
    check("y1_x7", 64'(pix[7:0]), 64'd0);
    check("y1_model", pix, model(y));

    y = '{255, 0, 0, 0, 0, 0, 0, 0};
    run_row(y, 0, pix);
    check("clip_high", pix, {8{8'hff}});

    y = '{-256, 0, 0, 0, 0, 0, 0, 0};
    run_row(y, 0, pix);
    check("clip_low", pix, 64'd0);

    for (int i = 0; i < 8; i++) y[i] = int'($urandom_range(0, 511)) - 256;
    run_row(y, 5, pix);
    check("stalled_row", pix, model(y));
    for (int i = 0; i < 8; i++) y[i] = int'($urandom_range(0, 511)) - 256;
    run_row(y, 0, pix);
    check("back_to_back", pix, model(y));

    // abort a row mid-accumulation, then confirm the next row is clean
    for (int i = 0; i < 8; i++) y[i] = int'($urandom_range(0, 511)) - 256;
    y[7] = 37;
    @(negedge clk);
    din      = pack(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out", dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) y[i] = int'($urandom_range(0, 511)) - 256;
    run_row(y, 0, pix);
    check("after_abort", pix, model(y));

    for (int t = 0; t < 40; t++) begin
      lz = int'($urandom_range(0, 8)) - 1;
      for (int i = 0; i < 8; i++)
        y[i] = (i <= lz) ? int'($urandom_range(0, 511)) - 256 : 0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) y[i] = int'($urandom_range(0, 80)) - 40;
      run_row(y, int'($urandom_range(0, 3)), pix);
      check("random_row", pix, model(y));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
